// File: rtl/decode_pipe.sv
// RV32 decode stage with a two-entry (output + skid) elastic buffer.
// Classifies each instruction, extracts fields/immediate, precomputes branch/JAL targets.
module decode_pipe #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-3:0] in_addr,
    input  logic [31:0]           in_insn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-3:0] out_addr,
    output logic [3:0]            out_class,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [31:0]           out_imm,
    output logic [ADDR_WIDTH-3:0] out_target,
    output logic                  out_misaligned,
    output logic [CNT_WIDTH-1:0]  cnt_insn,
    output logic [CNT_WIDTH-1:0]  cnt_branch
);

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_LUI     = 4'd1,
        CLS_AUIPC   = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_JALR    = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LOAD    = 4'd6,
        CLS_STORE   = 4'd7,
        CLS_ALU_IMM = 4'd8,
        CLS_ALU_REG = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_SYSTEM  = 4'd11
    } insn_class_e;

    typedef struct packed {
        logic [ADDR_WIDTH-3:0] addr;
        insn_class_e           cls;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [31:0]           imm;
        logic [ADDR_WIDTH-3:0] target;
        logic                  misaligned;
    } entry_t;

    entry_t                dec;
    entry_t                out_q;
    entry_t                skid_q;
    logic                  out_valid_q;
    logic                  skid_valid_q;
    logic                  in_ready_q;
    logic [ADDR_WIDTH-1:0] byte_tgt;
    logic [CNT_WIDTH-1:0]  cnt_insn_q;
    logic [CNT_WIDTH-1:0]  cnt_branch_q;
    logic                  accept;
    logic                  xfer;
    logic                  out_is_branch;

    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        dec          = '0;
        byte_tgt     = '0;
        dec.addr     = in_addr;
        dec.rd       = in_insn[11:7];
        dec.rs1      = in_insn[19:15];
        dec.rs2      = in_insn[24:20];
        dec.cls      = CLS_ILLEGAL;
        case (in_insn[6:0])
            7'h37: begin dec.cls = CLS_LUI;     dec.imm = {in_insn[31:12], 12'b0}; end
            7'h17: begin dec.cls = CLS_AUIPC;   dec.imm = {in_insn[31:12], 12'b0}; end
            7'h6f: begin
                dec.cls = CLS_JAL;
                dec.imm = {{12{in_insn[31]}}, in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};
            end
            7'h67: begin dec.cls = CLS_JALR;    dec.imm = {{20{in_insn[31]}}, in_insn[31:20]}; end
            7'h63: begin
                dec.cls = CLS_BRANCH;
                dec.imm = {{20{in_insn[31]}}, in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
            end
            7'h03: begin dec.cls = CLS_LOAD;    dec.imm = {{20{in_insn[31]}}, in_insn[31:20]}; end
            7'h23: begin
                dec.cls = CLS_STORE;
                dec.imm = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
            end
            7'h13: begin dec.cls = CLS_ALU_IMM; dec.imm = {{20{in_insn[31]}}, in_insn[31:20]}; end
            7'h33: dec.cls = CLS_ALU_REG;
            7'h0f: dec.cls = CLS_FENCE;
            7'h73: dec.cls = CLS_SYSTEM;
            default: dec.cls = CLS_ILLEGAL;
        endcase
        // Target arithmetic wraps at the address width; only branches and JAL carry one.
        if (dec.cls == CLS_BRANCH || dec.cls == CLS_JAL) begin
            byte_tgt       = {in_addr, 2'b00} + ADDR_WIDTH'($signed(dec.imm));
            dec.target     = byte_tgt[ADDR_WIDTH-1:2];
            dec.misaligned = |byte_tgt[1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (xfer || !out_valid_q) begin
            // Output slot frees up: oldest data (skid) first, else the incoming instruction.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
        end
    end

    // NOTE: the skid payload is qualified by skid_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept && out_valid_q && !xfer) begin
            skid_q <= dec;
        end
    end

    assign out_is_branch = (out_q.cls == CLS_BRANCH) || (out_q.cls == CLS_JAL) ||
                           (out_q.cls == CLS_JALR);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_insn_q   <= '0;
            cnt_branch_q <= '0;
        end else if (xfer && !flush) begin
            if (cnt_insn_q != '1) begin
                cnt_insn_q <= cnt_insn_q + CNT_WIDTH'(1);
            end
            if (out_is_branch && cnt_branch_q != '1) begin
                cnt_branch_q <= cnt_branch_q + CNT_WIDTH'(1);
            end
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_addr       = out_q.addr;
    assign out_class      = out_q.cls;
    assign out_rd         = out_q.rd;
    assign out_rs1        = out_q.rs1;
    assign out_rs2        = out_q.rs2;
    assign out_imm        = out_q.imm;
    assign out_target     = out_q.target;
    assign out_misaligned = out_q.misaligned;
    assign cnt_insn       = cnt_insn_q;
    assign cnt_branch     = cnt_branch_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed self-checking bench for decode_pipe (ADDR_WIDTH=32, CNT_WIDTH=4).
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_addr = '0;
    logic [31:0] in_insn = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [29:0] out_addr;
    logic [3:0]  out_class;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic [29:0] out_target;
    logic        out_misaligned;
    logic [3:0]  cnt_insn;
    logic [3:0]  cnt_branch;

    int n_checks = 0;
    int n_errors = 0;

    decode_pipe #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_insn(in_insn),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_target(out_target), .out_misaligned(out_misaligned),
        .cnt_insn(cnt_insn), .cnt_branch(cnt_branch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] insn;
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [29:0] tgt;
        logic        mis;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [29:0] a, input logic [31:0] i);
        in_valid = 1'b1;
        in_addr  = a;
        in_insn  = i;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_in_ready"}, in_ready, 1);
        check({pfx, "_cnt_insn"}, cnt_insn, 0);
        check({pfx, "_cnt_branch"}, cnt_branch, 0);
        check({pfx, "_class"}, out_class, 0);
        check({pfx, "_addr"}, out_addr, 0);
        check({pfx, "_imm"}, out_imm, 0);
        check({pfx, "_target"}, out_target, 0);
        check({pfx, "_misaligned"}, out_misaligned, 0);
        check({pfx, "_regs"}, {out_rd, out_rs1, out_rs2}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_insn;
        int exp_br;
        logic [31:0] got_q [$];

        vecs = '{
            '{30'h40,       32'h00000463, 4'd5,  32'h00000008, 30'h42,       1'b0, 5'd8,  5'd0,  5'd0},
            '{30'h40,       32'hFFDFF06F, 4'd3,  32'hFFFFFFFC, 30'h3F,       1'b0, 5'd0,  5'd31, 5'd29},
            '{30'h40,       32'h00000163, 4'd5,  32'h00000002, 30'h40,       1'b1, 5'd2,  5'd0,  5'd0},
            '{30'h0,        32'hFFDFF06F, 4'd3,  32'hFFFFFFFC, 30'h3FFFFFFF, 1'b0, 5'd0,  5'd31, 5'd29},
            '{30'h10,       32'h123450B7, 4'd1,  32'h12345000, 30'h0,        1'b0, 5'd1,  5'd8,  5'd3},
            '{30'h11,       32'h002081B3, 4'd9,  32'h00000000, 30'h0,        1'b0, 5'd3,  5'd1,  5'd2},
            '{30'h12,       32'h0020A423, 4'd7,  32'h00000008, 30'h0,        1'b0, 5'd8,  5'd1,  5'd2},
            '{30'h13,       32'hFFF00093, 4'd8,  32'hFFFFFFFF, 30'h0,        1'b0, 5'd1,  5'd0,  5'd31},
            '{30'h14,       32'h00000000, 4'd0,  32'h00000000, 30'h0,        1'b0, 5'd0,  5'd0,  5'd0},
            '{30'h15,       32'h00008067, 4'd4,  32'h00000000, 30'h0,        1'b0, 5'd0,  5'd1,  5'd0},
            '{30'h16,       32'h00004501, 4'd0,  32'h00000000, 30'h0,        1'b0, 5'd10, 5'd0,  5'd0},
            '{30'h17,       32'h00001517, 4'd2,  32'h00001000, 30'h0,        1'b0, 5'd10, 5'd0,  5'd0},
            '{30'h18,       32'h0FF0000F, 4'd10, 32'h00000000, 30'h0,        1'b0, 5'd0,  5'd0,  5'd31},
            '{30'h19,       32'h00000073, 4'd11, 32'h00000000, 30'h0,        1'b0, 5'd0,  5'd0,  5'd0},
            '{30'h1A,       32'hFFC12283, 4'd6,  32'hFFFFFFFC, 30'h0,        1'b0, 5'd5,  5'd2,  5'd28}
        };

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("init");

        // Decode table, streamed back-to-back with the consumer always ready
        out_ready = 1'b1;
        exp_insn  = 0;
        exp_br    = 0;
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].addr, vecs[i].insn);
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_addr", i), out_addr, vecs[i].addr);
            check($sformatf("v%0d_class", i), out_class, vecs[i].cls);
            check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            check($sformatf("v%0d_target", i), out_target, vecs[i].tgt);
            check($sformatf("v%0d_mis", i), out_misaligned, vecs[i].mis);
            check($sformatf("v%0d_regs", i), {out_rd, out_rs1, out_rs2},
                  {vecs[i].rd, vecs[i].rs1, vecs[i].rs2});
            check($sformatf("v%0d_cnt_insn", i), cnt_insn, exp_insn);
            check($sformatf("v%0d_cnt_branch", i), cnt_branch, exp_br);
            if (exp_insn < 15) exp_insn++;
            if ((vecs[i].cls == 4'd3 || vecs[i].cls == 4'd4 || vecs[i].cls == 4'd5) && exp_br < 15)
                exp_br++;
        end
        tick();
        check("table_drain_valid", out_valid, 0);
        check("table_cnt_insn", cnt_insn, 15);
        check("table_cnt_branch", cnt_branch, 5);

        // Backpressure: only two entries fit while stalled
        out_ready = 1'b0;
        send(30'h20, 32'h00100093);
        check("bp_ready_after_1", in_ready, 1);
        send(30'h21, 32'h00200093);
        check("bp_ready_after_2", in_ready, 0);
        check("bp_valid", out_valid, 1);
        in_valid = 1'b1;
        in_addr  = 30'h22;
        in_insn  = 32'h00300093;
        tick();
        check("bp_ready_held", in_ready, 0);
        check("bp_imm_stable", out_imm, 32'h1);
        check("bp_addr_stable", out_addr, 30'h20);
        begin
            int sent = 2;
            out_ready = 1'b1;
            for (int c = 0; c < 20; c++) begin
                logic fire_in;
                logic fire_out;
                fire_in  = in_valid && in_ready;
                fire_out = out_valid && out_ready;
                if (fire_out) got_q.push_back(out_imm);
                tick();
                if (fire_in) sent++;
                if (sent < 4) begin
                    in_addr  = 30'h20 + 30'(sent);
                    in_insn  = {12'(sent + 1), 20'h00093};
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("bp_count", got_q.size(), 4);
        for (int k = 0; k < got_q.size() && k < 4; k++)
            check($sformatf("bp_order%0d", k), got_q[k], k + 1);
        check("bp_drained", out_valid, 0);

        // Flush while full and stalled; flush beats the simultaneous handshakes
        out_ready = 1'b0;
        send(30'h40, 32'h00000463);
        send(30'h40, 32'h00000163);
        check("fl_full", in_ready, 0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_insn   = 32'h00700093;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_cnt_insn", cnt_insn, 15);
        check("fl_cnt_branch", cnt_branch, 5);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("fl_empty%0d", c), out_valid, 0);
        end
        send(30'h30, 32'h00800093);
        check("fl_next_valid", out_valid, 1);
        check("fl_next_imm", out_imm, 32'h8);
        check("fl_next_addr", out_addr, 30'h30);
        tick();
        check("fl_next_drained", out_valid, 0);
        check("fl_cnt_branch_after", cnt_branch, 5);

        // Counter saturation with 4-bit counters
        in_valid = 1'b1;
        in_addr  = 30'h40;
        in_insn  = 32'h00000463;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 9) check("sat_branch_mid", cnt_branch, 14);
        end
        in_valid = 1'b0;
        tick();
        check("sat_cnt_insn", cnt_insn, 15);
        check("sat_cnt_branch", cnt_branch, 15);

        // Reset mid-stream with both entries full; reset beats flush and handshakes
        out_ready = 1'b0;
        send(30'h50, 32'h00100093);
        send(30'h51, 32'h00000463);
        check("rst_full", in_ready, 0);
        rst       = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_reset_state("mid_rst");
        tick();
        check("mid_rst_stays_empty", out_valid, 0);
        send(30'h40, 32'h00000463);
        check("post_rst_class", out_class, 5);
        check("post_rst_imm", out_imm, 32'h8);
        check("post_rst_target", out_target, 30'h42);
        tick();
        check("post_rst_cnt_insn", cnt_insn, 1);
        check("post_rst_cnt_branch", cnt_branch, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width; instruction addresses carried as word addresses [ADDR_WIDTH-1:2].
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of statistics counters.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, discard all buffered instructions.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), upstream handshake.
REQ-007 SHALL have ports in_addr (input, ADDR_WIDTH-2, word address) and in_insn (input, 32, RV32 instruction).
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1), downstream handshake.
REQ-009 SHALL have port out_addr, output, ADDR_WIDTH-2, word address of the presented instruction.
REQ-010 SHALL have port out_class, output, 4: 0 ILLEGAL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 ALU_IMM, 9 ALU_REG, 10 FENCE, 11 SYSTEM.
REQ-011 SHALL have ports out_rd, out_rs1, out_rs2, each output, 5, register fields.
REQ-012 SHALL have port out_imm, output, 32, sign-extended immediate.
REQ-013 SHALL have ports out_target (output, ADDR_WIDTH-2, word target) and out_misaligned (output, 1, byte target bits [1:0] nonzero).
REQ-014 SHALL have ports cnt_insn and cnt_branch, each output, CNT_WIDTH, statistics.

Function
REQ-015 SHALL hold up to 2 entries: output register plus skid register; order strictly preserved.
REQ-016 SHALL drive in_ready from a register; in_ready=1 exactly when the skid entry is empty.
REQ-017 SHALL accept input on in_valid&&in_ready; decode is combinational on in_insn and the result is stored; latency 1 cycle (accepted at edge N, visible when out_valid rises after edge N if the output is empty).
REQ-018 SHALL complete output transfer on out_valid&&out_ready; if skid full, skid moves to output on that edge; simultaneous accept and transfer with skid empty refills the output register directly.
REQ-019 SHALL hold all out_* fields stable while out_valid=1 and out_ready=0.
REQ-020 SHALL classify ILLEGAL when in_insn[1:0]!=2'b11 or opcode is not one of the 11 listed classes.
REQ-021 SHALL form out_imm per RV32 I/S/B/U/J format for the class; ALU_REG, FENCE, SYSTEM, ILLEGAL give 0.
REQ-022 SHALL compute byte target = {addr,2'b00} + out_imm for BRANCH and JAL, modulo 2^ADDR_WIDTH (wrap-around, no flag); out_target = byte target [ADDR_WIDTH-1:2]; out_misaligned = |target[1:0]; other classes give out_target=0, out_misaligned=0.
REQ-023 SHALL output register fields as raw bit fields regardless of class.
REQ-024 SHALL, when flush=1, empty both entries at that edge, ignore any input presented that cycle, and drive in_ready=1, out_valid=0 next cycle; flush dominates simultaneous handshakes.
REQ-025 SHALL increment cnt_insn on each output transfer, and cnt_branch on each transfer of class BRANCH, JAL or JALR; both saturate at all-ones; flush does not clear them.

Reset
REQ-026 SHALL, with rst=1 at an edge, set out_valid=0, in_ready=1, skid empty, cnt_insn=0, cnt_branch=0, out_class=0, and all other out_* fields 0.
REQ-027 SHALL discard in-flight entries and ignore handshakes in any cycle with rst=1; rst dominates flush.

Verification
REQ-028 BRANCH: byte addr 0x100, insn 0x00000463, out_ready=1 -> next cycle out_valid=1, class 5, imm 8, byte target 0x108, misaligned 0.
REQ-029 JAL/misaligned: insn 0xFFDFF06F at 0x100 -> imm 0xFFFFFFFC, byte target 0x0FC; insn 0x00000163 at 0x100 -> byte target 0x102, out_target 0x40, misaligned 1.
REQ-030 Backpressure: out_ready=0, stream 4 valid insns -> 2 accepted, in_ready=0 after second; out_ready=1 -> all 4 delivered in order, none lost or duplicated.
REQ-031 Flush while full and stalled -> next cycle out_valid=0, in_ready=1; counters unchanged; flushed insns never appear.
REQ-032 CNT_WIDTH=4, 20 transfers of insn 0x00000463 -> cnt_insn=15, cnt_branch=15; insn 0x00000000 -> class 0.
REQ-033 rst asserted mid-stream with both entries full -> next cycle all REQ-026 values; first post-reset insn decoded normally.
